// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single-port
// data RAM. Fixed three-state transaction (IDLE -> ACCESS -> RESP), with access
// faults detected at acceptance and reported on the winner's response.
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 40
) (
  input  logic        clk,
  input  logic        reset,
  // requester 0 (CPU MEM stage)
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_funct3,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  // requester 1 (DMA / loader)
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_funct3,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  // RAM port
  output logic        ram_we,
  output logic        ram_half_en,
  output logic        ram_byte_en,
  output logic [2:0]  ram_funct3,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]  state_q,  state_d;
  logic        prio_q,   prio_d;    // id that wins a tie
  logic        id_q,     id_d;      // id of the current winner
  logic        we_q,     we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q,   addr_d;
  logic [31:0] wdata_q,  wdata_d;
  logic        err_q,    err_d;
  logic [31:0] rdata_q,  rdata_d;

  logic        grant0_c, grant1_c;
  logic        win_c;
  logic        sel_we_c;
  logic [2:0]  sel_funct3_c;
  logic [31:0] sel_addr_c;
  logic [31:0] sel_wdata_c;
  logic        in_access_c, in_resp_c;

  // Fault check on a request at acceptance time.
  function automatic logic calc_fault(input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    if (addr >= 32'(ADDR_LIMIT)) bad = 1'b1;
    if (!(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU))
      bad = 1'b1;
    if (we && (f3 == F3_BU || f3 == F3_HU)) bad = 1'b1;
    if ((f3 == F3_H || f3 == F3_HU) && addr[0]) bad = 1'b1;
    if (f3 == F3_W && addr[1:0] != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  // Winner selection: tie goes to prio_q, a lone requester always wins.
  always_comb begin
    win_c        = (m0_req && m1_req) ? prio_q : m1_req;
    sel_we_c     = win_c ? m1_we     : m0_we;
    sel_funct3_c = win_c ? m1_funct3 : m0_funct3;
    sel_addr_c   = win_c ? m1_addr   : m0_addr;
    sel_wdata_c  = win_c ? m1_wdata  : m0_wdata;
  end

  // Next-state, grant and capture logic.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    id_d     = id_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          grant0_c = ~win_c;
          grant1_c = win_c;
          id_d     = win_c;
          prio_d   = ~win_c;
          we_d     = sel_we_c;
          funct3_d = sel_funct3_c;
          addr_d   = sel_addr_c;
          wdata_d  = sel_wdata_c;
          err_d    = calc_fault(sel_we_c, sel_funct3_c, sel_addr_c);
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rdata_d = (!we_q && !err_q) ? ram_rdata : 32'd0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Output decode; reset forces every output low in the same cycle.
  always_comb begin
    in_access_c = (state_q == ST_ACCESS) && !reset;
    in_resp_c   = (state_q == ST_RESP) && !reset;

    m0_ready    = grant0_c && !reset;
    m1_ready    = grant1_c && !reset;

    ram_we      = in_access_c && we_q && !err_q;
    ram_half_en = in_access_c && we_q && (funct3_q == F3_H);
    ram_byte_en = in_access_c && we_q && (funct3_q == F3_B);
    ram_funct3  = in_access_c ? funct3_q : 3'd0;
    ram_addr    = in_access_c ? addr_q   : 32'd0;
    ram_wdata   = in_access_c ? wdata_q  : 32'd0;

    m0_rvalid   = in_resp_c && !id_q;
    m1_rvalid   = in_resp_c && id_q;
    m0_rdata    = m0_rvalid ? rdata_q : 32'd0;
    m1_rdata    = m1_rvalid ? rdata_q : 32'd0;
    m0_err      = m0_rvalid && err_q;
    m1_err      = m1_rvalid && err_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small byte-addressed RAM model.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we;
  logic [2:0]  m0_funct3;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_ready, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we;
  logic [2:0]  m1_funct3;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_ready, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic        ram_we, ram_half_en, ram_byte_en;
  logic [2:0]  ram_funct3;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int n_vec;
  int n_bad;

  dmem_arbiter #(.ADDR_LIMIT(40)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_funct3(m0_funct3), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_funct3(m1_funct3), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_we(ram_we), .ram_half_en(ram_half_en), .ram_byte_en(ram_byte_en),
    .ram_funct3(ram_funct3), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: little-endian bytes, combinational read with extension.
  logic [7:0] mem [0:63];
  logic [5:0] ra0, ra1, ra2, ra3;
  logic [7:0] b0, b1, b2, b3;
  assign ra0 = ram_addr[5:0];
  assign ra1 = ra0 + 6'd1;
  assign ra2 = ra0 + 6'd2;
  assign ra3 = ra0 + 6'd3;
  assign b0  = mem[ra0];
  assign b1  = mem[ra1];
  assign b2  = mem[ra2];
  assign b3  = mem[ra3];

  always_comb begin
    case (ram_funct3)
      3'b000:  ram_rdata = {{24{b0[7]}}, b0};
      3'b001:  ram_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  ram_rdata = {b3, b2, b1, b0};
      3'b100:  ram_rdata = {24'd0, b0};
      3'b101:  ram_rdata = {16'd0, b1, b0};
      default: ram_rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (ram_we) begin
      case (ram_funct3)
        3'b000: mem[ra0] <= ram_wdata[7:0];
        3'b001: begin
          mem[ra0] <= ram_wdata[7:0];
          mem[ra1] <= ram_wdata[15:8];
        end
        3'b010: begin
          mem[ra0] <= ram_wdata[7:0];
          mem[ra1] <= ram_wdata[15:8];
          mem[ra2] <= ram_wdata[23:16];
          mem[ra3] <= ram_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_reqs();
    m0_req = 1'b0; m0_we = 1'b0; m0_funct3 = 3'd0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_funct3 = 3'd0; m1_addr = 32'd0; m1_wdata = 32'd0;
  endtask

  // One full transaction from IDLE; records observations, leaves the DUT in IDLE.
  task automatic run_txn(input int port, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic rdy, output logic we_seen,
                         output logic byte_seen, output logic half_seen,
                         output logic [31:0] raddr_seen, output logic [31:0] rwdata_seen,
                         output logic vld, output logic [31:0] rd, output logic er);
    @(negedge clk);
    if (port == 0) begin
      m0_req = 1'b1; m0_we = we; m0_funct3 = f3; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_funct3 = f3; m1_addr = addr; m1_wdata = wdata;
    end
    #1;
    rdy = (port == 0) ? (m0_ready && !m1_ready) : (m1_ready && !m0_ready);
    @(posedge clk); #1;
    clear_reqs();
    we_seen     = ram_we;
    byte_seen   = ram_byte_en;
    half_seen   = ram_half_en;
    raddr_seen  = ram_addr;
    rwdata_seen = ram_wdata;
    @(posedge clk); #1;
    if (port == 0) begin
      vld = m0_rvalid && !m1_rvalid && (m1_rdata == 32'd0) && !m1_err;
      rd  = m0_rdata;
      er  = m0_err;
    end else begin
      vld = m1_rvalid && !m0_rvalid && (m0_rdata == 32'd0) && !m0_err;
      rd  = m1_rdata;
      er  = m1_err;
    end
    we_seen = we_seen | ram_we;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    clear_reqs();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_funct3 = 3'b010; m0_addr = 32'h8; m0_wdata = 32'h55;
    m1_req = 1'b1; m1_funct3 = 3'b010;
    #1;
    flags = {m0_ready, m1_ready, m0_rvalid, m1_rvalid, m0_err, m1_err,
             ram_we, ram_half_en, ram_byte_en};
    n_vec++;
    if (flags !== 9'd0) begin
      n_bad++; $display("FAIL reset_flags: got %b, required 000000000", flags);
    end
    n_vec++;
    if ((m0_rdata | m1_rdata | ram_addr | ram_wdata | {29'd0, ram_funct3}) !== 32'd0) begin
      n_bad++; $display("FAIL reset_data: got nonzero bus data, required 0");
    end
    @(posedge clk); #1;
    n_vec++;
    if ({m0_ready, m1_ready, ram_we, m0_rvalid, m1_rvalid} !== 5'd0) begin
      n_bad++; $display("FAIL reset_hold: outputs active while reset high, required 0");
    end
    clear_reqs();
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    logic rdy, wes, bs, hs, vld, er;
    logic [31:0] ra, rw, rd;
    run_txn(0, 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL sw_ready: got %b, required 1", rdy); end
    n_vec++;
    if ({wes, ra, rw} !== {1'b1, 32'h8, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL sw_access: we=%b addr=%h wdata=%h, required 1/00000008/deadbeef", wes, ra, rw);
    end
    n_vec++;
    if ({vld, er, rd} !== {1'b1, 1'b0, 32'd0}) begin
      n_bad++; $display("FAIL sw_resp: vld=%b err=%b rdata=%h, required 1/0/00000000", vld, er, rd);
    end
    run_txn(0, 1'b0, 3'b010, 32'h8, 32'h0, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({vld, er, wes} !== 3'b100) begin
      n_bad++; $display("FAIL lw_flags: vld=%b err=%b we=%b, required 1/0/0", vld, er, wes);
    end
    n_vec++;
    if (rd !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL lw_data: got %h, required deadbeef", rd);
    end
  endtask

  task automatic test_byte();
    logic rdy, wes, bs, hs, vld, er;
    logic [31:0] ra, rw, rd;
    run_txn(0, 1'b1, 3'b000, 32'h3, 32'h00000080, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({wes, bs, hs, er} !== 4'b1100) begin
      n_bad++; $display("FAIL sb_access: we=%b byte=%b half=%b err=%b, required 1/1/0/0", wes, bs, hs, er);
    end
    run_txn(0, 1'b0, 3'b000, 32'h3, 32'h0, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({vld, bs, wes, rd} !== {3'b100, 32'hFFFFFF80}) begin
      n_bad++; $display("FAIL lb: vld=%b byte=%b we=%b rdata=%h, required 1/0/0/ffffff80", vld, bs, wes, rd);
    end
    run_txn(0, 1'b0, 3'b100, 32'h3, 32'h0, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({vld, bs, rd} !== {2'b10, 32'h00000080}) begin
      n_bad++; $display("FAIL lbu: vld=%b byte=%b rdata=%h, required 1/0/00000080", vld, bs, rd);
    end
  endtask

  task automatic test_faults();
    logic rdy, wes, bs, hs, vld, er;
    logic [31:0] ra, rw, rd;
    run_txn(1, 1'b1, 3'b001, 32'h5, 32'hABCD, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({rdy, vld, er, wes, rd} !== {4'b1110, 32'd0}) begin
      n_bad++; $display("FAIL sh_misalign: rdy=%b vld=%b err=%b we=%b rdata=%h, required 1/1/1/0/0", rdy, vld, er, wes, rd);
    end
    run_txn(1, 1'b0, 3'b010, 32'h28, 32'h0, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({vld, er, rd} !== {2'b11, 32'd0}) begin
      n_bad++; $display("FAIL lw_range: vld=%b err=%b rdata=%h, required 1/1/0", vld, er, rd);
    end
    run_txn(1, 1'b0, 3'b010, 32'h6, 32'h0, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({vld, er, rd} !== {2'b11, 32'd0}) begin
      n_bad++; $display("FAIL lw_misalign: vld=%b err=%b rdata=%h, required 1/1/0", vld, er, rd);
    end
    run_txn(1, 1'b0, 3'b011, 32'h8, 32'h0, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({vld, er} !== 2'b11) begin
      n_bad++; $display("FAIL bad_funct3: vld=%b err=%b, required 1/1", vld, er);
    end
    run_txn(1, 1'b1, 3'b100, 32'h8, 32'h0, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({vld, er, wes} !== 3'b110) begin
      n_bad++; $display("FAIL store_bu: vld=%b err=%b we=%b, required 1/1/0", vld, er, wes);
    end
    run_txn(1, 1'b0, 3'b010, 32'h24, 32'h0, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({vld, er} !== 2'b10) begin
      n_bad++; $display("FAIL lw_last_word: vld=%b err=%b, required 1/0", vld, er);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, wes, bs, hs, vld, er;
    logic [31:0] ra, rw, rd;
    logic seen_v;
    run_txn(0, 1'b1, 3'b010, 32'h4, 32'hAABBCCDD, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_funct3 = 3'b010; m0_addr = 32'h4; m0_wdata = 32'h12345678;
    @(posedge clk); #1;
    clear_reqs();
    reset = 1'b1;
    #1;
    n_vec++;
    if (ram_we !== 1'b0) begin
      n_bad++; $display("FAIL reset_access_we: got %b, required 0", ram_we);
    end
    seen_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      seen_v = seen_v | m0_rvalid | m1_rvalid;
    end
    n_vec++;
    if (seen_v !== 1'b0) begin
      n_bad++; $display("FAIL reset_drop: rvalid seen=%b, required 0", seen_v);
    end
    run_txn(0, 1'b0, 3'b010, 32'h4, 32'h0, rdy, wes, bs, hs, ra, rw, vld, rd, er);
    n_vec++;
    if ({vld, rd} !== {1'b1, 32'hAABBCCDD}) begin
      n_bad++; $display("FAIL reset_prior: vld=%b rdata=%h, required 1/aabbccdd", vld, rd);
    end
  endtask

  task automatic test_wait();
    @(negedge clk);
    m0_req = 1'b1; m0_funct3 = 3'b010; m0_addr = 32'h8;
    @(posedge clk); #1;
    m0_req = 1'b0;
    m1_req = 1'b1; m1_funct3 = 3'b010; m1_addr = 32'h0;
    #1;
    n_vec++;
    if (m1_ready !== 1'b0) begin n_bad++; $display("FAIL wait_access: m1_ready=%b, required 0", m1_ready); end
    @(posedge clk); #1;
    n_vec++;
    if ({m1_ready, m0_rvalid, m0_rdata} !== {2'b01, 32'hDEADBEEF}) begin
      n_bad++; $display("FAIL wait_resp: m1_ready=%b m0_rvalid=%b m0_rdata=%h, required 0/1/deadbeef", m1_ready, m0_rvalid, m0_rdata);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({m1_ready, m0_ready} !== 2'b10) begin
      n_bad++; $display("FAIL wait_accept: m1_ready=%b m0_ready=%b, required 1/0", m1_ready, m0_ready);
    end
    @(posedge clk); #1;
    clear_reqs();
    n_vec++;
    if ({ram_funct3, ram_addr} !== {3'b010, 32'h0}) begin
      n_bad++; $display("FAIL wait_m1_access: funct3=%b addr=%h, required 010/0", ram_funct3, ram_addr);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({m1_rvalid, m0_rvalid, m1_err} !== 3'b100) begin
      n_bad++; $display("FAIL wait_m1_resp: m1_rvalid=%b m0_rvalid=%b err=%b, required 1/0/0", m1_rvalid, m0_rvalid, m1_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic exp1;
    do_reset();
    m0_req = 1'b1; m0_funct3 = 3'b010; m0_addr = 32'h8;
    m1_req = 1'b1; m1_funct3 = 3'b010; m1_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      exp1 = (k % 2) == 1;
      #1;
      n_vec++;
      if ({m0_ready, m1_ready} !== {~exp1, exp1}) begin
        n_bad++; $display("FAIL rr_grant%0d: ready m0/m1=%b%b, required %b%b", k, m0_ready, m1_ready, ~exp1, exp1);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({m0_ready, m1_ready} !== 2'b00) begin
        n_bad++; $display("FAIL rr_access%0d: ready m0/m1=%b%b, required 00", k, m0_ready, m1_ready);
      end
      @(posedge clk); #1;
      n_vec++;
      if ({m0_rvalid, m1_rvalid, m0_ready, m1_ready} !== {~exp1, exp1, 2'b00}) begin
        n_bad++; $display("FAIL rr_resp%0d: rvalid m0/m1=%b%b ready=%b%b, required %b%b00", k, m0_rvalid, m1_rvalid, m0_ready, m1_ready, ~exp1, exp1);
      end
      @(posedge clk);
    end
    #1;
    clear_reqs();
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    clear_reqs();
    test_reset();
    test_store_load();
    test_byte();
    test_faults();
    test_reset_mid();
    test_wait();
    test_round_robin();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
